// File: rtl/status_flag_unit_pkg.sv
// Shared definitions for the status flag unit: flag indices, condition codes,
// FSM state encoding and the status width.
package status_flag_unit_pkg;

    localparam int STATUS_W = 4;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NK = 4'b1111;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/status_flag_unit_if.sv
// Pipeline-facing signal bundle of the status flag unit; the pipeline side
// drives through master, the flag unit sits on slave.
interface status_flag_unit_if
    import status_flag_unit_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic                flush;
    logic                freeze;
    logic                exe_valid;
    logic                exe_s;
    logic                exe_mc;
    logic [STATUS_W-1:0] exe_status;
    logic [STATUS_W-1:0] mc_status;
    logic                id_cond_used;
    logic [STATUS_W-1:0] status;
    logic [STATUS_W-1:0] status_fwd;
    logic                flag_hazard;
    logic                exe_stall;
    logic                mc_busy;
    logic [CNT_W-1:0]    upd_count;

    modport master (
        output flush, freeze, exe_valid, exe_s, exe_mc, exe_status, mc_status, id_cond_used,
        input  status, status_fwd, flag_hazard, exe_stall, mc_busy, upd_count
    );

    modport slave (
        input  flush, freeze, exe_valid, exe_s, exe_mc, exe_status, mc_status, id_cond_used,
        output status, status_fwd, flag_hazard, exe_stall, mc_busy, upd_count
    );
endinterface

// File: rtl/status_flag_unit_flag_latency_timer.sv
// IDLE/BUSY tracker for a pending multi-cycle flag write; counts down the
// remaining latency and flags the final BUSY cycle.
module flag_latency_timer
    import status_flag_unit_pkg::*;
#(
    parameter int MC_LAT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic clr,
    output logic busy,
    output logic last
);
    localparam logic [3:0] LOAD_VAL = 4'(MC_LAT - 1);

    state_e     state_r;
    state_e     state_nxt_s;
    logic [3:0] lat_cnt_r;
    logic [3:0] lat_cnt_nxt_s;
    logic       busy_s;
    logic       last_s;

    assign busy_s = (state_r == BUSY);
    assign last_s = busy_s & (lat_cnt_r == 4'd0);

    // State and latency counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            lat_cnt_r <= 4'd0;
        end else begin
            state_r   <= state_nxt_s;
            lat_cnt_r <= lat_cnt_nxt_s;
        end
    end

    // Next state: load on start, count down while busy; clr overrides everything
    always_comb begin
        state_nxt_s   = state_r;
        lat_cnt_nxt_s = lat_cnt_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s   = BUSY;
                    lat_cnt_nxt_s = LOAD_VAL;
                end else begin
                    lat_cnt_nxt_s = 4'd0;
                end
            end
            BUSY: begin
                if (lat_cnt_r == 4'd0) begin
                    state_nxt_s = IDLE;
                end else begin
                    lat_cnt_nxt_s = lat_cnt_r - 4'd1;
                end
            end
            default: begin
                state_nxt_s   = IDLE;
                lat_cnt_nxt_s = 4'd0;
            end
        endcase
        if (clr) begin
            state_nxt_s   = IDLE;
            lat_cnt_nxt_s = 4'd0;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    assign busy = busy_s;
    assign last = last_s;
endmodule

// File: rtl/status_flag_unit.sv
// Processor status register with same-cycle flag bypass, multi-cycle flag
// write tracking, ID flag hazard and EXE stall generation.
module status_flag_unit
    import status_flag_unit_pkg::*;
#(
    parameter int MC_LAT = 3,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    status_flag_unit_if.slave  bus
);
    logic                wr_req_s;
    logic                busy_s;
    logic                last_s;
    logic                mc_start_s;
    logic                commit_exe_s;
    logic                commit_mc_s;
    logic [STATUS_W-1:0] status_r;
    logic [STATUS_W-1:0] status_fwd_s;
    logic [CNT_W-1:0]    upd_count_r;

    assign wr_req_s     = bus.exe_valid & bus.exe_s & ~bus.freeze & ~bus.flush;
    assign mc_start_s   = ~busy_s & wr_req_s & bus.exe_mc;
    assign commit_exe_s = ~busy_s & wr_req_s & ~bus.exe_mc;
    // A flush on the final BUSY cycle discards the multi-cycle result
    assign commit_mc_s  = last_s & ~bus.flush;

    flag_latency_timer #(.MC_LAT(MC_LAT)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .start (mc_start_s),
        .clr   (bus.flush),
        .busy  (busy_s),
        .last  (last_s)
    );

    // Status register and committed-write counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_r    <= 4'b0000;
            upd_count_r <= {CNT_W{1'b0}};
        end else begin
            if (commit_exe_s) begin
                status_r <= bus.exe_status;
            end else if (commit_mc_s) begin
                status_r <= bus.mc_status;
            end else begin
                status_r <= status_r;
            end
            if (commit_exe_s | commit_mc_s) begin
                upd_count_r <= upd_count_r + CNT_W'(1);
            end else begin
                upd_count_r <= upd_count_r;
            end
        end
    end

    // Bypass the value about to be committed so the condition check sees it now
    always_comb begin
        status_fwd_s = status_r;
        if (commit_exe_s) begin
            status_fwd_s = bus.exe_status;
        end else if (commit_mc_s) begin
            status_fwd_s = bus.mc_status;
        end else begin
            status_fwd_s = status_r;
        end
    end

    assign bus.status      = status_r;
    assign bus.status_fwd  = status_fwd_s;
    assign bus.upd_count   = upd_count_r;
    assign bus.mc_busy     = busy_s;
    assign bus.exe_stall   = busy_s & bus.exe_valid & bus.exe_s;
    assign bus.flag_hazard = bus.id_cond_used & ((busy_s & ~last_s) | mc_start_s);
endmodule

// File: doc/status_flag_unit.md
Name: status_flag_unit

Overview:
- Owns the processor status register (flags Z, C, N, V) and produces the 4-bit status vector that feeds the ID-stage condition check.
- Commits ALU flags from EXE when the instruction sets S, and bypasses them to the condition check in the same cycle.
- Tracks multi-cycle flag-setting operations (multiply-class) with a latency counter. Raises a hazard so that ID-stage conditional instructions wait until those flags are final.

Parameters:
- MC_LAT, 3, cycles a multi-cycle flag-setting op occupies before its flags are valid (legal range 1..15).
- CNT_W, 16, width of the status-update event counter.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- flush  input  1  pipeline flush; kills the EXE instruction and any pending multi-cycle flag write
- freeze  input  1  pipeline freeze; EXE-stage write requests are ignored while high
- exe_valid  input  1  EXE stage holds a real instruction
- exe_s  input  1  EXE instruction sets flags
- exe_mc  input  1  EXE instruction is multi-cycle
- exe_status  input  4  ALU flags {Z,C,N,V}, bit3=Z, bit2=C, bit1=N, bit0=V
- mc_status  input  4  multi-cycle unit flags, same order; valid in the final BUSY cycle
- id_cond_used  input  1  ID instruction's condition reads flags (cond not AL and not NK)
- status  output  4  registered status register, same bit order
- status_fwd  output  4  bypassed status presented to the condition check
- flag_hazard  output  1  ID must stall; its flags are not yet available
- exe_stall  output  1  EXE must hold; a flag write cannot be accepted this cycle
- mc_busy  output  1  multi-cycle flag write pending
- upd_count  output  CNT_W  number of committed status writes, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, immediate):
  - status=0, state=IDLE, lat_cnt=0, upd_count=0.
  - Combinational outputs then evaluate to flag_hazard=0, exe_stall=0, mc_busy=0, status_fwd=0.
- Definitions:
  - wr_req = exe_valid & exe_s & ~freeze & ~flush.
  - last = (state==BUSY) & (lat_cnt==0).
- States: IDLE, BUSY. mc_busy = (state==BUSY).
- IDLE, wr_req & ~exe_mc:
  - status <= exe_status at the next edge.
  - status_fwd = exe_status in this cycle (zero-latency bypass).
  - upd_count increments.
- IDLE, wr_req & exe_mc:
  - Next edge: state <= BUSY, lat_cnt <= MC_LAT-1. status is unchanged.
  - status_fwd = status.
- BUSY, not last: lat_cnt decrements every cycle, independent of freeze.
- BUSY, last:
  - status <= mc_status, state <= IDLE, upd_count increments.
  - status_fwd = mc_status in this cycle.
- MC_LAT=1: exactly one BUSY cycle, which is also the last cycle.
- Otherwise status_fwd = status.
- flag_hazard = id_cond_used & ((state==BUSY & ~last) | (state==IDLE & wr_req & exe_mc)).
- exe_stall = (state==BUSY) & exe_valid & exe_s, including the last cycle, where the multi-cycle write wins. The held EXE write commits in the following IDLE cycle.
- flush:
  - Highest priority. Forces state <= IDLE next edge and discards the pending multi-cycle write.
  - status is not written and upd_count does not increment.
  - flush on the last cycle also discards the write.
- freeze: blocks only new EXE writes. It does not block BUSY progress or the last-cycle commit.
- exe_s=0 or exe_valid=0: no effect on status.
- Multi-cycle ops without S are not tracked by this block.
- Reset asserted mid-BUSY: returns immediately to reset values. No write occurs.
- upd_count wraps from all-ones to 0 with no saturation.

Decomposition:
- Shared package:
  - Flag bit indices FLAG_Z=3, FLAG_C=2, FLAG_N=1, FLAG_V=0.
  - The 16 condition-code constants (EQ..NK, 4'b0000..4'b1111).
  - State encoding: IDLE, BUSY.
  - Status width constant 4.
- One natural sub-module: flag_latency_timer. It holds the load/decrement/last logic for lat_cnt and exposes busy and last.

Test Plan:
- Reset, then single-cycle S write: exe_valid=1, exe_s=1, exe_mc=0, exe_status=4'b1000 → status_fwd=4'b1000 in the same cycle; status=4'b1000 after the edge; upd_count=1.
- Multi-cycle, MC_LAT=3, id_cond_used=1, mc_status=4'b0110:
  - flag_hazard=1 in the start cycle and the first 2 BUSY cycles.
  - In the last BUSY cycle, flag_hazard=0 and status_fwd=4'b0110.
  - Next cycle: status=4'b0110, mc_busy=0.
- EXE S write during BUSY: exe_stall=1 on every BUSY cycle. The write commits in the first IDLE cycle; upd_count advances by 2 in total.
- flush in the second BUSY cycle → IDLE next edge; status keeps its prior value (4'b1000); upd_count unchanged.
- freeze=1 with wr_req conditions otherwise met → status unchanged, upd_count unchanged. With freeze=1 in the last BUSY cycle, mc_status still commits.
- Async rst pulse mid-BUSY between edges → status=0, mc_busy=0, upd_count=0 immediately. Also drive 2^CNT_W writes and confirm upd_count wraps to 0.
